oam_dma_controller: RTL and testbench
=====================================

// Module: oam_dma_controller
// PURPOSE
//  Owns the OAM DMA engine (register FF46) and arbitrates the CPU bus against it. Sits between
//  the CPU bus master and the downstream decode. Routes CPU accesses to a main port
//  (0000-FEFF) or a high port (FF00-FFFF). While DMA runs, it steals the main port to copy
//  160 bytes into OAM and restricts the CPU to HRAM.
// PARAMETERS
//  DMA_LEN      160    bytes per transfer (OAM size)
//  DMA_REG_ADDR 16'hFF46  DMA source/start register address
// PORTS
//  clk           in   1   clock
//  reset         in   1   reset, asynchronous, active-high
//  t_phase       in   2   CPU T-phase (t_phase_t T1..T4); an M-cycle ends at T4
//  cpu_addr      in   16  CPU address
//  cpu_wdata     in   8   CPU write data
//  cpu_read_en   in   1   CPU read strobe
//  cpu_write_en  in   1   CPU write strobe
//  cpu_rdata     out  8   read data to CPU (combinational)
//  main_addr     out  16  main-port address (0000-FEFF region)
//  main_wdata    out  8   main-port write data
//  main_read_en  out  1   main-port read strobe
//  main_write_en out  1   main-port write strobe
//  main_rdata    in   8   main-port read data
//  hi_addr/hi_wdata/hi_read_en/hi_write_en  out 16/8/1/1  high port (FF00-FFFF except FF46)
//  hi_rdata      in   8   high-port read data
//  oam_addr      out  8   OAM write index
//  oam_wdata     out  8   OAM write data
//  oam_write_en  out  1   OAM write strobe, one T-phase wide
//  dma_active    out  1   high while bytes are being transferred
// BEHAVIOUR
//  Reset: state=IDLE, src=8'h00, idx=0, dma_active=0, oam_write_en=0, oam_addr=0,
//   oam_wdata=0. All main/hi strobes are 0 and addresses are 0.
//  FSM (advances only at T4 unless noted): IDLE -> START -> ACTIVE -> IDLE.
//  Register write:
//   - Trigger: cpu_write_en && cpu_addr==FF46 sampled at T3 of M-cycle N.
//   - Action: src<=cpu_wdata, idx<=0, state<=START.
//   - This also applies in START or ACTIVE: a restart aborts the current transfer, and no
//     further OAM writes from the old src occur.
//  Register read: reading FF46 returns src in any state. FF46 never reaches the hi port.
//  START: occupies M-cycle N+1 and does not touch the bus. At T4 it moves to ACTIVE.
//  ACTIVE: byte k is transferred in M-cycle N+2+k, for k = 0..159.
//   - T1: main_addr={src_eff, idx}.
//   - T2-T3: main_read_en=1.
//   - T3: latch main_rdata into data_q.
//   - T4: oam_addr=idx, oam_wdata=data_q, oam_write_en=1. Then idx increments.
//   - At T4 with idx==DMA_LEN-1: state<=IDLE and dma_active drops. The CPU is unblocked
//     from T1 of M-cycle N+162.
//  src_eff: src when src<8'hE0, else src-8'h20 (echo mirror). There is no fault case.
//  dma_active: 1 exactly in ACTIVE, registered and changing at T4 boundaries.
//  CPU routing when not ACTIVE:
//   - Decode is transparent: cpu_addr<FF00 goes to main, otherwise to hi.
//   - Strobes, data and rdata pass through combinationally with zero added latency.
//   - The unselected port's strobes are 0.
//  CPU routing while ACTIVE:
//   - cpu_addr in FF80-FFFE: passes to the hi port as normal.
//   - FF46: handled internally as above.
//   - Any other address: writes are dropped (no downstream strobe). Reads return the
//     blocked value (see CONFIGURATION). The main port stays owned by DMA.
//  START does not block the CPU.
//  Simultaneous events: a CPU FF46 write at T3 of the last ACTIVE cycle takes priority.
//   That cycle's OAM write still completes, and the FSM goes to START rather than IDLE.
//  idx is 8 bits wide. It never wraps, because the compare against DMA_LEN-1 ends the
//   transfer.
//  Async reset mid-transfer: returns to the reset state immediately, and OAM is not written
//   again.
// CONFIGURATION
//  OAM_DMA_CONFLICT_EN
//   - Defined: blocked CPU reads return data_q (the byte currently in flight), emulating
//     the bus conflict.
//   - Undefined: blocked CPU reads return 8'hFF.
//   - Everything else is identical in both builds.
// TESTING
//  1. Idle: CPU reads C000 and FF80 -> main_read_en/hi_read_en asserted respectively,
//     cpu_rdata equals the port data, other port strobes 0.
//  2. Write FF46=C1 with main memory preloaded C100+i=i^8'h5A -> one START M-cycle with no
//     bus activity, then 160 OAM writes with oam_addr=i and oam_wdata=i^5A, in order, one
//     per M-cycle. dma_active is high for exactly 160 M-cycles.
//  3. During ACTIVE: CPU write to C000 -> no main write issued. CPU read of C000 -> FF (or
//     the in-flight byte with OAM_DMA_CONFLICT_EN). CPU read/write of FF80 -> hi port
//     strobes normal.
//  4. Restart: FF46=C1, then at byte 50 write FF46=D0 -> OAM 0..49 come from C1xx, then
//     START, then OAM 0..159 come from D0xx. Reading FF46 returns D0.
//  5. FF46=E3 -> source reads issue at E3xx-0x2000 = C3xx (main_addr C300..C39F).
//  6. Assert reset at byte 80 -> dma_active=0 and oam_write_en=0 immediately. No further
//     OAM writes. A subsequent FF46 read returns 00.

Source files
------------

// File: rtl/oam_dma_controller.sv
// OAM DMA engine (FF46) and CPU bus arbiter: routes CPU accesses to the main or high port
// and steals the main port for a 160-byte OAM copy. Optional build macro: OAM_DMA_CONFLICT_EN.
module oam_dma_controller #(
  parameter int unsigned DMA_LEN      = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_phase,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_read_en,
  input  logic        cpu_write_en,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] main_addr,
  output logic [7:0]  main_wdata,
  output logic        main_read_en,
  output logic        main_write_en,
  input  logic [7:0]  main_rdata,
  output logic [15:0] hi_addr,
  output logic [7:0]  hi_wdata,
  output logic        hi_read_en,
  output logic        hi_write_en,
  input  logic [7:0]  hi_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_write_en,
  output logic        dma_active
);

  localparam logic [1:0] T1 = 2'd0;
  localparam logic [1:0] T2 = 2'd1;
  localparam logic [1:0] T3 = 2'd2;
  localparam logic [1:0] T4 = 2'd3;
  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {IDLE, START, ACTIVE} state_t;

  state_t      state_q;
  logic [7:0]  src_q;
  logic [7:0]  idx_q;
  logic [7:0]  idx_d;
  logic [7:0]  data_q;
  logic [7:0]  oam_addr_q;
  logic        oam_we_q;
  logic        restart_q;
  logic        dma_active_q;

  logic        busOwned;
  logic        cpuIsReg;
  logic        cpuIsHi;
  logic        cpuIsHram;
  logic        hiAllowed;
  logic [7:0]  srcEff;
  logic [7:0]  blockedData;

  assign busOwned  = (state_q == ACTIVE);
  assign cpuIsReg  = (cpu_addr == DMA_REG_ADDR);
  assign cpuIsHi   = (cpu_addr >= 16'hFF00) && !cpuIsReg;
  assign cpuIsHram = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
  assign hiAllowed = cpuIsHi && (!busOwned || cpuIsHram);
  assign srcEff    = (src_q < 8'hE0) ? src_q : (src_q - 8'h20);
  assign idx_d     = idx_q + 8'd1;

`ifdef OAM_DMA_CONFLICT_EN
  assign blockedData = data_q;
`else
  assign blockedData = 8'hFF;
`endif

  // A register write is captured at T3 but only takes effect on the FSM at T4, so the
  // in-flight byte still lands in OAM before the restart drops into START.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= 8'h00;
      idx_q        <= 8'h00;
      data_q       <= 8'h00;
      oam_addr_q   <= 8'h00;
      oam_we_q     <= 1'b0;
      restart_q    <= 1'b0;
      dma_active_q <= 1'b0;
    end else begin
      oam_we_q <= (t_phase == T3) && (state_q == ACTIVE);
      if (t_phase == T3) begin
        if (state_q == ACTIVE) begin
          data_q     <= main_rdata;
          oam_addr_q <= idx_q;
        end
        if (cpu_write_en && cpuIsReg) begin
          src_q     <= cpu_wdata;
          restart_q <= 1'b1;
        end
      end
      if (t_phase == T4) begin
        restart_q <= 1'b0;
        if (restart_q) begin
          state_q      <= START;
          idx_q        <= 8'h00;
          dma_active_q <= 1'b0;
        end else begin
          case (state_q)
            START: begin
              state_q      <= ACTIVE;
              dma_active_q <= 1'b1;
            end
            ACTIVE: begin
              if (idx_q == LAST_IDX) begin
                state_q      <= IDLE;
                dma_active_q <= 1'b0;
              end else begin
                idx_q <= idx_d;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  // While the transfer owns the main port, the CPU only reaches HRAM and FF46.
  always_comb begin
    main_addr     = 16'h0000;
    main_wdata    = 8'h00;
    main_read_en  = 1'b0;
    main_write_en = 1'b0;
    hi_addr       = 16'h0000;
    hi_wdata      = 8'h00;
    hi_read_en    = 1'b0;
    hi_write_en   = 1'b0;
    cpu_rdata     = blockedData;
    if (busOwned) begin
      main_addr    = {srcEff, idx_q};
      main_read_en = (t_phase == T2) || (t_phase == T3);
    end else if (!cpuIsHi && !cpuIsReg) begin
      main_addr     = cpu_addr;
      main_wdata    = cpu_wdata;
      main_read_en  = cpu_read_en;
      main_write_en = cpu_write_en;
      cpu_rdata     = main_rdata;
    end
    if (hiAllowed) begin
      hi_addr     = cpu_addr;
      hi_wdata    = cpu_wdata;
      hi_read_en  = cpu_read_en;
      hi_write_en = cpu_write_en;
      cpu_rdata   = hi_rdata;
    end
    if (cpuIsReg) begin
      cpu_rdata = src_q;
    end
  end

  assign oam_addr     = oam_addr_q;
  assign oam_wdata    = data_q;
  assign oam_write_en = oam_we_q;
  assign dma_active   = dma_active_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: a scoreboard queue of expected OAM writes and DMA
// source addresses is filled when a transfer is started and drained by a negedge monitor.
module tb_oam_dma_controller;

  localparam logic [1:0] T1 = 2'd0;
  localparam logic [1:0] T2 = 2'd1;
  localparam logic [1:0] T3 = 2'd2;
  localparam logic [1:0] T4 = 2'd3;

  logic        clk;
  logic        reset;
  logic [1:0]  t_phase;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_read_en;
  logic        cpu_write_en;
  logic [7:0]  cpu_rdata;
  logic [15:0] main_addr;
  logic [7:0]  main_wdata;
  logic        main_read_en;
  logic        main_write_en;
  logic [7:0]  main_rdata;
  logic [15:0] hi_addr;
  logic [7:0]  hi_wdata;
  logic        hi_read_en;
  logic        hi_write_en;
  logic [7:0]  hi_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_write_en;
  logic        dma_active;

  int          checks = 0;
  int          errors = 0;
  int          oamCount = 0;
  int          activeCycles = 0;
  logic [7:0]  lastOamData = 8'h00;
  logic [15:0] expOam[$];
  logic [15:0] expMain[$];
  logic [7:0]  blockedExp;

  oam_dma_controller dut (
    .clk(clk), .reset(reset), .t_phase(t_phase),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read_en(cpu_read_en),
    .cpu_write_en(cpu_write_en), .cpu_rdata(cpu_rdata),
    .main_addr(main_addr), .main_wdata(main_wdata), .main_read_en(main_read_en),
    .main_write_en(main_write_en), .main_rdata(main_rdata),
    .hi_addr(hi_addr), .hi_wdata(hi_wdata), .hi_read_en(hi_read_en),
    .hi_write_en(hi_write_en), .hi_rdata(hi_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_write_en(oam_write_en),
    .dma_active(dma_active)
  );

  // Main memory image chosen so C1xx holds i^5A and other pages differ.
  function automatic logic [7:0] memByte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC1;
  endfunction

  assign main_rdata = memByte(main_addr);
  assign hi_rdata   = hi_addr[7:0] ^ 8'hA5;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial t_phase = T1;
  always @(posedge clk) #1 t_phase = t_phase + 2'd1;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic waitPhase(input logic [1:0] p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (t_phase !== p && n < 8);
    if (t_phase !== p) begin
      checks++;
      errors++;
      $display("[TB] FAIL phase_sync: observed=%0d expected=%0d", t_phase, p);
    end
  endtask

  task automatic waitOam(input int target);
    int n;
    n = 0;
    while (oamCount < target && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (oamCount < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL oam_timeout: observed=%0d expected=%0d", oamCount, target);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                               input logic rd, input logic wr);
    waitPhase(T1);
    cpu_addr     = a;
    cpu_wdata    = d;
    cpu_read_en  = rd;
    cpu_write_en = wr;
    #1;
  endtask

  task automatic endAccess();
    waitPhase(T4);
    cpu_addr     = 16'h0000;
    cpu_wdata    = 8'h00;
    cpu_read_en  = 1'b0;
    cpu_write_en = 1'b0;
  endtask

  task automatic cpuWriteReg(input logic [7:0] v);
    applyStimulus(16'hFF46, v, 1'b0, 1'b1);
    waitPhase(T2);
    checkOutput("reg_write_no_hi", {15'd0, hi_write_en}, 16'd0);
    endAccess();
  endtask

  task automatic pushDma(input logic [7:0] src);
    logic [7:0] se;
    logic [7:0] ii;
    se = (src < 8'hE0) ? src : (src - 8'h20);
    for (int i = 0; i < 160; i++) begin
      ii = 8'(i);
      expOam.push_back({ii, memByte({se, ii})});
      expMain.push_back({se, ii});
    end
    oamCount     = 0;
    activeCycles = 0;
  endtask

  // Scoreboard drain: each OAM write and each ACTIVE T1 source address is popped in order.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!reset) begin
      if (t_phase == T4 && oam_write_en) begin
        checkOutput("oam_expected", {15'd0, expOam.size() > 0}, 16'd1);
        if (expOam.size() > 0) begin
          e = expOam.pop_front();
          checkOutput("oam_write", {oam_addr, oam_wdata}, e);
        end
        lastOamData = oam_wdata;
        oamCount++;
      end
      if (t_phase != T4) checkOutput("oam_we_phase", {15'd0, oam_write_en}, 16'd0);
      if (t_phase == T1 && dma_active) begin
        activeCycles++;
        if (expMain.size() > 0) begin
          e = expMain.pop_front();
          checkOutput("dma_src_addr", main_addr, e);
        end
      end
    end
  end

  initial begin
`ifdef OAM_DMA_CONFLICT_EN
    $display("[TB] build with bus-conflict read data");
`endif
    reset        = 1'b1;
    cpu_addr     = 16'h0000;
    cpu_wdata    = 8'h00;
    cpu_read_en  = 1'b0;
    cpu_write_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_dma_active", {15'd0, dma_active}, 16'd0);
    checkOutput("rst_oam_we", {15'd0, oam_write_en}, 16'd0);
    checkOutput("rst_oam_addr", {8'd0, oam_addr}, 16'd0);
    checkOutput("rst_oam_wdata", {8'd0, oam_wdata}, 16'd0);
    checkOutput("rst_main_addr", main_addr, 16'd0);
    checkOutput("rst_strobes", {12'd0, main_read_en, main_write_en, hi_read_en, hi_write_en}, 16'd0);
    checkOutput("rst_hi_addr", hi_addr, 16'd0);
    reset = 1'b0;

    // Idle routing.
    applyStimulus(16'hC000, 8'h00, 1'b1, 1'b0);
    checkOutput("idle_main_rd", {14'd0, main_read_en, hi_read_en}, 16'b10);
    checkOutput("idle_main_rdata", {8'd0, cpu_rdata}, {8'd0, memByte(16'hC000)});
    endAccess();
    applyStimulus(16'hFF80, 8'h00, 1'b1, 1'b0);
    checkOutput("idle_hi_rd", {14'd0, main_read_en, hi_read_en}, 16'b01);
    checkOutput("idle_hi_rdata", {8'd0, cpu_rdata}, 16'h0025);
    endAccess();
    applyStimulus(16'hC123, 8'h9C, 1'b0, 1'b1);
    checkOutput("idle_main_wr", {main_write_en, hi_write_en, 6'd0, main_wdata}, 16'h809C);
    endAccess();

    // Full transfer from C1xx with blocked CPU traffic mixed in.
    pushDma(8'hC1);
    cpuWriteReg(8'hC1);
    waitPhase(T2);
    checkOutput("start_idle_bus", {14'd0, dma_active, main_read_en}, 16'd0);
    waitPhase(T2);
    checkOutput("byte0_bus", {14'd0, dma_active, main_read_en}, 16'b11);
    waitOam(10);
    applyStimulus(16'hC000, 8'h77, 1'b0, 1'b1);
    waitPhase(T2);
    checkOutput("blk_main_wr", {15'd0, main_write_en}, 16'd0);
    endAccess();
    applyStimulus(16'hC000, 8'h00, 1'b1, 1'b0);
    waitPhase(T2);
`ifdef OAM_DMA_CONFLICT_EN
    blockedExp = lastOamData;
`else
    blockedExp = 8'hFF;
`endif
    checkOutput("blk_main_rdata", {8'd0, cpu_rdata}, {8'd0, blockedExp});
    checkOutput("blk_main_rd_addr", main_addr, 16'hC10B);
    endAccess();
    applyStimulus(16'hFF00, 8'h11, 1'b0, 1'b1);
    waitPhase(T2);
    checkOutput("blk_ff00_wr", {15'd0, hi_write_en}, 16'd0);
    endAccess();
    applyStimulus(16'hFF80, 8'h00, 1'b1, 1'b0);
    waitPhase(T2);
    checkOutput("hram_rd", {14'd0, hi_read_en, main_read_en}, 16'b11);
    checkOutput("hram_rdata", {8'd0, cpu_rdata}, 16'h0025);
    endAccess();
    applyStimulus(16'hFF81, 8'h05, 1'b0, 1'b1);
    waitPhase(T2);
    checkOutput("hram_wr", {hi_write_en, 7'd0, hi_wdata}, 16'h8005);
    endAccess();
    applyStimulus(16'hFFFF, 8'h00, 1'b1, 1'b0);
    waitPhase(T2);
    checkOutput("blk_ffff_rd", {15'd0, hi_read_en}, 16'd0);
    endAccess();
    waitOam(160);
    applyStimulus(16'hC000, 8'h00, 1'b1, 1'b0);
    checkOutput("unblock_rd", {14'd0, dma_active, main_read_en}, 16'b01);
    checkOutput("unblock_rdata", {8'd0, cpu_rdata}, {8'd0, memByte(16'hC000)});
    endAccess();
    checkOutput("c1_active_cycles", 16'(activeCycles), 16'd160);
    checkOutput("c1_queue_empty", 16'(expOam.size()), 16'd0);

    // Restart mid-transfer: bytes 0..49 from C1, then a full copy from D0.
    pushDma(8'hC1);
    cpuWriteReg(8'hC1);
    waitOam(49);
    cpuWriteReg(8'hD0);
    #1;
    checkOutput("restart_old_count", 16'(oamCount), 16'd50);
    checkOutput("restart_old_left", 16'(expOam.size()), 16'd110);
    expOam.delete();
    expMain.delete();
    pushDma(8'hD0);
    waitPhase(T2);
    checkOutput("restart_start", {15'd0, dma_active}, 16'd0);
    waitOam(20);
    applyStimulus(16'hFF46, 8'h00, 1'b1, 1'b0);
    checkOutput("reg_read_d0", {7'd0, hi_read_en, cpu_rdata}, 16'h00D0);
    endAccess();
    waitOam(160);
    checkOutput("d0_queue_empty", 16'(expOam.size()), 16'd0);

    // Echo-region source.
    pushDma(8'hE3);
    cpuWriteReg(8'hE3);
    waitOam(160);
    checkOutput("e3_queue_empty", 16'(expMain.size()), 16'd0);

    // Asynchronous reset during byte 80.
    pushDma(8'hC1);
    cpuWriteReg(8'hC1);
    waitOam(80);
    waitPhase(T4);
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_mid_active", {14'd0, dma_active, oam_write_en}, 16'd0);
    expOam.delete();
    expMain.delete();
    checkOutput("rst_mid_count", 16'(oamCount), 16'd81);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("rst_no_more_oam", 16'(oamCount), 16'd81);
    applyStimulus(16'hFF46, 8'h00, 1'b1, 1'b0);
    checkOutput("rst_reg_read", {8'd0, cpu_rdata}, 16'h0000);
    endAccess();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
